multi_pwm_motor_driver: RTL and testbench

//   N-channel PWM motor driver; parametrised successor to the fixed pwm/motor_direction PIO pair.
//   Per channel: glitch-free PWM, slew-limited duty ramp, enforced decel+deadtime on direction

---
 rtl/multi_pwm_motor_driver.sv | 252 +++++++++++++++++++++++++
 tb/tb_multi_pwm_motor_driver.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_pwm_motor_driver.sv
// Purpose : N-channel PWM H-bridge driver with slew-limited duty, reversal deadtime and active brake.
// Latency : pwm_out/motor_direction are registered one clk after the shared counter/FSM state they
//           reflect; enable gates them combinationally. No backpressure: cmd_valid is always accepted.
//
// Ports
//   clk_clk, reset_reset_n : clock and async active-low reset (release resynchronised internally)
//   enable                 : global enable; low coasts every channel at once
//   cmd_valid              : one-cycle strobe latching cmd_duty/cmd_dir/cmd_brake for all channels
//   cmd_duty/dir/brake     : per-channel targets (duty of ch i at [i*PWM_BITS +: PWM_BITS])
//   pwm_out                : PWM per channel
//   motor_direction        : {IN2,IN1} per channel at [2i +: 2]; 00 coast, 01 fwd, 10 rev, 11 brake
//   period_tick            : one-cycle pulse following each PWM period boundary
//   ch_busy                : channel is decelerating for a reversal or sitting in deadtime
module multi_pwm_motor_driver #(
    parameter int NUM_CH    = 2,
    parameter int PWM_BITS  = 8,
    parameter int PRESCALE  = 4,
    parameter int RAMP_STEP = 4,
    parameter int DEADTIME  = 2
) (
    input  logic                         clk_clk,
    input  logic                         reset_reset_n,
    input  logic                         enable,
    input  logic                         cmd_valid,
    input  logic [NUM_CH*PWM_BITS-1:0]   cmd_duty,
    input  logic [NUM_CH-1:0]            cmd_dir,
    input  logic [NUM_CH-1:0]            cmd_brake,
    output logic [NUM_CH-1:0]            pwm_out,
    output logic [2*NUM_CH-1:0]          motor_direction,
    output logic                         period_tick,
    output logic [NUM_CH-1:0]            ch_busy
);

    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int DT_W = $clog2(DEADTIME + 1);
    localparam int DUTY_MAX = (1 << PWM_BITS) - 1;

    // The counter runs 0..2^PWM_BITS-2 so that a duty of 2^PWM_BITS-1 is a constant high output.
    localparam logic [PWM_BITS-1:0] CNT_MAX  = PWM_BITS'(DUTY_MAX - 1);
    localparam logic [PS_W-1:0]     PS_LAST  = PS_W'(PRESCALE - 1);
    // A step larger than full scale behaves exactly like full scale, so clamp it to fit the math width.
    localparam logic [PWM_BITS:0]   STEP_LIM = (RAMP_STEP > DUTY_MAX) ? (PWM_BITS+1)'(DUTY_MAX)
                                                                     : (PWM_BITS+1)'(RAMP_STEP);
    localparam logic [DT_W-1:0]     DT_LOAD  = DT_W'(DEADTIME);
    localparam logic [DT_W-1:0]     DT_ONE   = DT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_DECEL = 3'd2,
        S_DEAD  = 3'd3,
        S_BRAKE = 3'd4
    } state_t;

    // ------------------------------------------------------------------
    // Reset: assertion is asynchronous, release is aligned to the clock.
    // ------------------------------------------------------------------
    logic [1:0] rst_sync;
    logic       rst_n_sync;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_n_sync = rst_sync[1];

    // ------------------------------------------------------------------
    // Shared timebase: prescaler -> tick -> PWM counter -> period boundary.
    // ------------------------------------------------------------------
    logic [PS_W-1:0]     presc;
    logic [PWM_BITS-1:0] cnt;
    logic                tick;
    logic                boundary;
    logic                period_q;

    assign tick     = (presc == PS_LAST);
    assign boundary = tick && (cnt == CNT_MAX);

    always_ff @(posedge clk_clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            presc    <= '0;
            cnt      <= '0;
            period_q <= 1'b0;
        end else begin
            presc <= tick ? '0 : presc + 1'b1;
            if (tick) begin
                cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
            end
            period_q <= boundary;
        end
    end

    assign period_tick = period_q;

    // ------------------------------------------------------------------
    // Command targets: sticky until the next strobe. The FSMs only look at
    // them on a boundary, so a strobe landing on the boundary edge itself is
    // first acted upon one period later.
    // ------------------------------------------------------------------
    logic [NUM_CH*PWM_BITS-1:0] tgt_duty_q;
    logic [NUM_CH-1:0]          tgt_dir_q;
    logic [NUM_CH-1:0]          tgt_brake_q;

    always_ff @(posedge clk_clk or negedge rst_n_sync) begin
        if (!rst_n_sync) begin
            tgt_duty_q  <= '0;
            tgt_dir_q   <= '0;
            tgt_brake_q <= '0;
        end else if (cmd_valid) begin
            tgt_duty_q  <= cmd_duty;
            tgt_dir_q   <= cmd_dir;
            tgt_brake_q <= cmd_brake;
        end
    end

    // ------------------------------------------------------------------
    // Per-channel FSM, duty ramp and output registers.
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        state_t              state_q, state_nxt;
        logic [PWM_BITS-1:0] cur_q, cur_nxt;
        logic [PWM_BITS-1:0] tgt;
        logic                run_dir_q, run_dir_nxt;
        logic [DT_W-1:0]     dead_q, dead_nxt;
        logic [PWM_BITS:0]   cur_w, eff_w, step;
        logic [1:0]          dir_enc;
        logic                pwm_q;
        logic [1:0]          dir_q;

        assign tgt = tgt_duty_q[i*PWM_BITS +: PWM_BITS];

        // State register: dropping enable parks the channel in IDLE at zero duty.
        always_ff @(posedge clk_clk or negedge rst_n_sync) begin
            if (!rst_n_sync) begin
                state_q   <= S_IDLE;
                cur_q     <= '0;
                run_dir_q <= 1'b0;
                dead_q    <= '0;
            end else if (!enable) begin
                state_q   <= S_IDLE;
                cur_q     <= '0;
                dead_q    <= '0;
            end else if (boundary) begin
                state_q   <= state_nxt;
                cur_q     <= cur_nxt;
                run_dir_q <= run_dir_nxt;
                dead_q    <= dead_nxt;
            end
        end

        // Next state and next duty, both applied only at a period boundary.
        always_comb begin
            state_nxt   = state_q;
            run_dir_nxt = run_dir_q;
            dead_nxt    = dead_q;
            cur_nxt     = cur_q;
            eff_w       = '0;
            cur_w       = {1'b0, cur_q};
            step        = '0;

            if (tgt_brake_q[i]) begin
                state_nxt = S_BRAKE;
            end else begin
                case (state_q)
                    S_BRAKE: begin
                        state_nxt = S_DEAD;
                        dead_nxt  = DT_LOAD;
                    end
                    S_IDLE: begin
                        if (tgt != '0) begin
                            state_nxt   = S_RUN;
                            run_dir_nxt = tgt_dir_q[i];
                        end
                    end
                    S_RUN: begin
                        if (tgt_dir_q[i] != run_dir_q) begin
                            state_nxt = S_DECEL;
                        end else if ((tgt == '0) && (cur_q == '0)) begin
                            state_nxt = S_IDLE;
                        end
                    end
                    // A request that flips back to run_dir still rides the ramp to zero.
                    S_DECEL: begin
                        if (cur_q == '0) begin
                            state_nxt = S_DEAD;
                            dead_nxt  = DT_LOAD;
                        end
                    end
                    // The load value counts whole periods, so leave on the last one.
                    S_DEAD: begin
                        if (dead_q <= DT_ONE) begin
                            state_nxt = S_IDLE;
                            dead_nxt  = '0;
                        end else begin
                            dead_nxt = dead_q - 1'b1;
                        end
                    end
                    default: begin
                        state_nxt = S_IDLE;
                    end
                endcase
            end

            // Only RUN drives toward the commanded duty; every other state winds down to zero.
            // The ramp uses the state being entered, so IDLE->RUN already takes its first step.
            if (state_nxt == S_RUN) begin
                eff_w = {1'b0, tgt};
            end

            if (state_nxt == S_BRAKE) begin
                cur_nxt = '0;
            end else if (eff_w > cur_w) begin
                step    = ((eff_w - cur_w) > STEP_LIM) ? STEP_LIM : (eff_w - cur_w);
                cur_nxt = PWM_BITS'(cur_w + step);
            end else begin
                step    = ((cur_w - eff_w) > STEP_LIM) ? STEP_LIM : (cur_w - eff_w);
                cur_nxt = PWM_BITS'(cur_w - step);
            end
        end

        // Bridge pin encoding for the current state.
        always_comb begin
            dir_enc = 2'b00;
            case (state_q)
                S_RUN, S_DECEL: dir_enc = run_dir_q ? 2'b10 : 2'b01;
                S_BRAKE:        dir_enc = 2'b11;
                default:        dir_enc = 2'b00;
            endcase
        end

        // Registered pins give glitch-free edges; enable also clears them so a
        // one-cycle enable dip cannot replay a stale direction afterwards.
        always_ff @(posedge clk_clk or negedge rst_n_sync) begin
            if (!rst_n_sync) begin
                pwm_q <= 1'b0;
                dir_q <= 2'b00;
            end else begin
                pwm_q <= enable && (cnt < cur_q) && (state_q != S_BRAKE);
                dir_q <= enable ? dir_enc : 2'b00;
            end
        end

        assign pwm_out[i]              = pwm_q & enable;
        assign motor_direction[2*i +: 2] = dir_q & {2{enable}};
        assign ch_busy[i]              = (state_q == S_DECEL) || (state_q == S_DEAD);
    end

endmodule

// File: tb/tb_multi_pwm_motor_driver.sv
// Purpose : Self-checking bench for multi_pwm_motor_driver (4-bit duty, prescale 1, 2 channels).
// Latency : measures whole 15-clk PWM windows delimited by period_tick.
// Backpressure: none; commands are strobed at window starts or on the boundary cycle.
module tb_multi_pwm_motor_driver;

    localparam int NUM_CH    = 2;
    localparam int PWM_BITS  = 4;
    localparam int PRESCALE  = 1;
    localparam int RAMP_STEP = 4;
    localparam int DEADTIME  = 2;
    localparam int PER       = 15;
    localparam int NVEC      = 28;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enable = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_duty = '0;
    logic [1:0] cmd_dir = '0;
    logic [1:0] cmd_brake = '0;
    logic [1:0] pwm_out;
    logic [3:0] motor_direction;
    logic       period_tick;
    logic [1:0] ch_busy;

    always #5 clk = ~clk;

    multi_pwm_motor_driver #(
        .NUM_CH   (NUM_CH),
        .PWM_BITS (PWM_BITS),
        .PRESCALE (PRESCALE),
        .RAMP_STEP(RAMP_STEP),
        .DEADTIME (DEADTIME)
    ) dut (
        .clk_clk        (clk),
        .reset_reset_n  (rst_n),
        .enable         (enable),
        .cmd_valid      (cmd_valid),
        .cmd_duty       (cmd_duty),
        .cmd_dir        (cmd_dir),
        .cmd_brake      (cmd_brake),
        .pwm_out        (pwm_out),
        .motor_direction(motor_direction),
        .period_tick    (period_tick),
        .ch_busy        (ch_busy)
    );

    // cv: 0 no command, 1 strobe at window start, 2 strobe on the boundary cycle ending the window.
    typedef struct {
        int         cv;
        logic [3:0] d0, d1;
        logic [1:0] dir, brk;
        int         hi0, hi1;
        logic [1:0] m0, m1, busy;
    } vec_t;

    typedef struct {
        int         hi0, hi1;
        logic [1:0] m0, m1, busy;
    } exp_t;

    exp_t sb[$];
    vec_t tbl[NVEC];
    int   n_vec = 0;
    int   n_miss = 0;

    function automatic vec_t mk(input int cv, input int d0, input int d1, input int dir, input int brk,
                                input int hi0, input int hi1, input int m0, input int m1, input int busy);
        vec_t v;
        v.cv   = cv;
        v.d0   = 4'(d0);
        v.d1   = 4'(d1);
        v.dir  = 2'(dir);
        v.brk  = 2'(brk);
        v.hi0  = hi0;
        v.hi1  = hi1;
        v.m0   = 2'(m0);
        v.m1   = 2'(m1);
        v.busy = 2'(busy);
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int req);
        n_vec++;
        if (act != req) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, req);
        end
    endtask

    task automatic drive_cmd(input vec_t v);
        cmd_duty  = {v.d1, v.d0};
        cmd_dir   = v.dir;
        cmd_brake = v.brk;
        cmd_valid = 1'b1;
    endtask

    // Wait (bounded) for the negedge where period_tick is high: a window has just closed.
    task automatic sync_period(input string nm);
        bit got = 1'b0;
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if (period_tick) got = 1'b1;
        end
        chk(nm, int'(got), 1);
    endtask

    // One PWM window: 15 samples, ending on the sample where period_tick is high.
    task automatic run_period(input vec_t v, input int idx);
        exp_t       e;
        int         hi0 = 0, hi1 = 0, ns = 0, dchg = 0;
        logic [1:0] m0 = '0, m1 = '0, busy = '0;
        bit         done = 1'b0;
        e.hi0 = v.hi0; e.hi1 = v.hi1; e.m0 = v.m0; e.m1 = v.m1; e.busy = v.busy;
        sb.push_back(e);
        if (v.cv == 1) drive_cmd(v);
        for (int k = 0; k < 40 && !done; k++) begin
            @(posedge clk);
            #1 cmd_valid = 1'b0;
            @(negedge clk);
            ns++;
            hi0 += int'(pwm_out[0]);
            hi1 += int'(pwm_out[1]);
            if (ns == 1) begin
                m0   = motor_direction[1:0];
                m1   = motor_direction[3:2];
                busy = ch_busy;
            end else if (motor_direction != {m1, m0}) begin
                dchg++;
            end
            if (v.cv == 2 && ns == PER - 1) drive_cmd(v);
            if (period_tick) done = 1'b1;
        end
        e = sb.pop_front();
        chk($sformatf("v%0d period_len", idx), ns, PER);
        chk($sformatf("v%0d ch0_high", idx), hi0, e.hi0);
        chk($sformatf("v%0d ch1_high", idx), hi1, e.hi1);
        chk($sformatf("v%0d ch0_dir", idx), int'(m0), int'(e.m0));
        chk($sformatf("v%0d ch1_dir", idx), int'(m1), int'(e.m1));
        chk($sformatf("v%0d busy", idx), int'(busy), int'(e.busy));
        chk($sformatf("v%0d dir_stable", idx), dchg, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Ramp up, reversal with decel/deadtime, brake, boundary strobe, partial step, stop.
        tbl[0]  = mk(1, 15, 0, 0, 0,    0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0,     4, 0, 1, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0,     8, 0, 1, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0,    12, 0, 1, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0,    15, 0, 1, 0, 0);
        tbl[5]  = mk(1, 15, 8, 1, 0,   15, 0, 1, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0,    11, 4, 1, 1, 1);
        tbl[7]  = mk(0, 0, 0, 0, 0,     7, 8, 1, 1, 1);
        tbl[8]  = mk(0, 0, 0, 0, 0,     3, 8, 1, 1, 1);
        tbl[9]  = mk(0, 0, 0, 0, 0,     0, 8, 1, 1, 1);
        tbl[10] = mk(0, 0, 0, 0, 0,     0, 8, 0, 1, 1);
        tbl[11] = mk(0, 0, 0, 0, 0,     0, 8, 0, 1, 1);
        tbl[12] = mk(0, 0, 0, 0, 0,     0, 8, 0, 1, 0);
        tbl[13] = mk(0, 0, 0, 0, 0,     4, 8, 2, 1, 0);
        tbl[14] = mk(1, 15, 8, 1, 2,    8, 8, 2, 1, 0);
        tbl[15] = mk(1, 15, 8, 1, 0,   12, 0, 2, 3, 0);
        tbl[16] = mk(0, 0, 0, 0, 0,    15, 0, 2, 0, 2);
        tbl[17] = mk(0, 0, 0, 0, 0,    15, 0, 2, 0, 2);
        tbl[18] = mk(0, 0, 0, 0, 0,    15, 0, 2, 0, 0);
        tbl[19] = mk(0, 0, 0, 0, 0,    15, 4, 2, 1, 0);
        tbl[20] = mk(2, 3, 8, 1, 0,    15, 8, 2, 1, 0);
        tbl[21] = mk(1, 3, 10, 1, 0,   15, 8, 2, 1, 0);
        tbl[22] = mk(0, 0, 0, 0, 0,    11, 10, 2, 1, 0);
        tbl[23] = mk(0, 0, 0, 0, 0,     7, 10, 2, 1, 0);
        tbl[24] = mk(0, 0, 0, 0, 0,     3, 10, 2, 1, 0);
        tbl[25] = mk(1, 0, 10, 1, 0,    3, 10, 2, 1, 0);
        tbl[26] = mk(0, 0, 0, 0, 0,     0, 10, 2, 1, 0);
        tbl[27] = mk(0, 0, 0, 0, 0,     0, 10, 0, 1, 0);

        // Reset state.
        #12;
        chk("rst pwm_out", int'(pwm_out), 0);
        chk("rst motor_direction", int'(motor_direction), 0);
        chk("rst period_tick", int'(period_tick), 0);
        chk("rst ch_busy", int'(ch_busy), 0);
        @(negedge clk);
        rst_n  = 1'b1;
        enable = 1'b1;
        sync_period("sync after reset");

        for (int i = 0; i < NVEC; i++) begin
            run_period(tbl[i], i);
        end

        // Enable dropped mid-window: pins go quiet at once, channel restarts its ramp from 0.
        begin
            bit done = 1'b0;
            int ns = 0;
            for (int k = 0; k < 40 && !done; k++) begin
                @(negedge clk);
                ns++;
                if (ns == 5) begin
                    chk("en pre pwm1", int'(pwm_out[1]), 1);
                    chk("en pre dir1", int'(motor_direction[3:2]), 1);
                    enable = 1'b0;
                    #1;
                    chk("en low pwm_out", int'(pwm_out), 0);
                    chk("en low motor_direction", int'(motor_direction), 0);
                end
                if (ns == 7) begin
                    chk("en held pwm_out", int'(pwm_out), 0);
                    chk("en held ch_busy", int'(ch_busy), 0);
                end
                if (ns == 8) enable = 1'b1;
                if (period_tick) done = 1'b1;
            end
            chk("en window len", ns, PER);
        end
        run_period(mk(0, 0, 0, 0, 0, 0, 4, 0, 1, 0), 100);
        run_period(mk(0, 0, 0, 0, 0, 0, 8, 0, 1, 0), 101);
        run_period(mk(0, 0, 0, 0, 0, 0, 10, 0, 1, 0), 102);

        // Reset asserted mid-run: outputs clear without waiting for a clock.
        repeat (6) @(negedge clk);
        chk("midrst pre pwm1", int'(pwm_out[1]), 1);
        rst_n = 1'b0;
        #1;
        chk("midrst pwm_out", int'(pwm_out), 0);
        chk("midrst motor_direction", int'(motor_direction), 0);
        chk("midrst period_tick", int'(period_tick), 0);
        chk("midrst ch_busy", int'(ch_busy), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        sync_period("sync after midrst");
        run_period(mk(1, 0, 8, 0, 0, 0, 0, 0, 0, 0), 200);
        run_period(mk(0, 0, 0, 0, 0, 0, 4, 0, 1, 0), 201);
        run_period(mk(0, 0, 0, 0, 0, 0, 8, 0, 1, 0), 202);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
